// File: rtl/gact_fifo_read_scheduler.sv
// gact_fifo_read_scheduler
//   Shares one credit-flow-controlled consumer between NUM_REQ occupancy-counted
//   FIFOs. An idle scheduler picks a non-empty FIFO (round-robin from rr_ptr),
//   drains it in a burst of at most MAX_BURST reads, then spends one GAP cycle
//   so the FIFO counts settle before the next arbitration. Each issued read is
//   tracked through a RD_LATENCY-deep tag pipe so the returned word leaves
//   tagged with its source index and end-of-burst flag.
//
//   Build option: define GACT_SCHED_STRICT_PRIO_EN to make every arbitration
//   pick the lowest-index non-empty FIFO (rr_ptr then never moves from 0).
module gact_fifo_read_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH_WIDTH = 3,
   parameter int MAX_BURST   = 4,
   parameter int CREDITS     = 4,
   parameter int RD_LATENCY  = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ*(DEPTH_WIDTH+1)-1:0] fifo_count,
   output logic [NUM_REQ-1:0]                 fifo_rd_en,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]      fifo_rd_data,
   output logic                               out_valid,
   output logic [DATA_WIDTH-1:0]              out_data,
   output logic [$clog2(NUM_REQ)-1:0]         out_src,
   output logic                               out_last,
   input  logic                               credit_return,
   output logic                               busy
);

   localparam int SRC_W = $clog2(NUM_REQ);
   localparam int CNT_W = DEPTH_WIDTH + 1;
   localparam int CRD_W = $clog2(CREDITS + 1);
   localparam int TAIL  = RD_LATENCY - 1;

   localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);
   localparam logic [CRD_W-1:0] CREDITS_C   = CRD_W'(CREDITS);
   localparam logic [SRC_W-1:0] LAST_IDX    = SRC_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [SRC_W-1:0]      grant_q, grant_d;
   logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]      beats_left_q, beats_left_d;
   logic [CRD_W-1:0]      credits_q, credits_d;
   logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
   logic [RD_LATENCY-1:0] pipe_last_q, pipe_last_d;
   logic [SRC_W-1:0]      pipe_src_q [RD_LATENCY];
   logic [SRC_W-1:0]      pipe_src_d [RD_LATENCY];

   logic [CNT_W-1:0]      count_arr [NUM_REQ];
   logic [DATA_WIDTH-1:0] data_arr  [NUM_REQ];
   logic [NUM_REQ-1:0]    eligible;
   logic                  arb_found;
   logic [SRC_W-1:0]      arb_idx;
   logic [SRC_W:0]        rr_sum;
   logic [SRC_W-1:0]      rr_cand;
   logic [CNT_W-1:0]      burst_len;
   logic                  issue;

   // Unpack the flat per-FIFO count/data buses and flag non-empty FIFOs.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         count_arr[i] = fifo_count[i*CNT_W +: CNT_W];
         data_arr[i]  = fifo_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
         eligible[i]  = (count_arr[i] != '0);
      end
   end

   // Rotating search for the first eligible FIFO at or after rr_ptr; scanning
   // from the far end lets the nearest candidate overwrite the others.
   // NOTE: every signal written here gets a value before any branch, so no
   // path can leave it holding its old value and infer a latch.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      rr_sum    = '0;
      rr_cand   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         rr_sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
         if (rr_sum >= (SRC_W+1)'(NUM_REQ)) begin
            rr_sum = rr_sum - (SRC_W+1)'(NUM_REQ);
         end
         rr_cand = rr_sum[SRC_W-1:0];
         if (eligible[rr_cand]) begin
            arb_found = 1'b1;
            arb_idx   = rr_cand;
         end
      end
      burst_len = (count_arr[arb_idx] > MAX_BURST_C) ? MAX_BURST_C : count_arr[arb_idx];
   end

   // Next-state logic for the grant FSM, the credit counter and the tag pipe.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_ptr_d     = rr_ptr_q;
      beats_left_d = beats_left_q;
      credits_d    = credits_q;
      issue        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arb_found && (credits_q != '0)) begin
               grant_d      = arb_idx;
               beats_left_d = burst_len;
               state_d      = ST_BURST;
            end
         end
         ST_BURST: begin
            if (credits_q != '0) begin
               issue        = 1'b1;
               beats_left_d = beats_left_q - CNT_W'(1);
               if (beats_left_q == CNT_W'(1)) begin
                  state_d = ST_GAP;
`ifdef GACT_SCHED_STRICT_PRIO_EN
                  // rr_ptr is held at 0, so the rotating search is lowest-index-first.
                  rr_ptr_d = rr_ptr_q;
`else
                  rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + SRC_W'(1);
`endif
               end
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A read and a return in the same cycle cancel; returns beyond the
      // consumer's buffer size are dropped.
      if (issue && !credit_return) begin
         credits_d = credits_q - CRD_W'(1);
      end else if (!issue && credit_return && (credits_q != CREDITS_C)) begin
         credits_d = credits_q + CRD_W'(1);
      end

      pipe_vld_d[0]  = issue;
      pipe_last_d[0] = issue && (beats_left_q == CNT_W'(1));
      pipe_src_d[0]  = issue ? grant_q : '0;
      for (int s = 1; s < RD_LATENCY; s++) begin
         pipe_vld_d[s]  = pipe_vld_q[s-1];
         pipe_last_d[s] = pipe_last_q[s-1];
         pipe_src_d[s]  = pipe_src_q[s-1];
      end
   end

   // State registers; reset also discards any beat still in the tag pipe.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         rr_ptr_q     <= '0;
         beats_left_q <= '0;
         credits_q    <= CREDITS_C;
         pipe_vld_q   <= '0;
         pipe_last_q  <= '0;
         // NOTE: the tag storage is small and cleared with the valid bits so
         // no stale source index survives reset; wide data memories would
         // normally be left unreset.
         for (int s = 0; s < RD_LATENCY; s++) begin
            pipe_src_q[s] <= '0;
         end
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         rr_ptr_q     <= rr_ptr_d;
         beats_left_q <= beats_left_d;
         credits_q    <= credits_d;
         pipe_vld_q   <= pipe_vld_d;
         pipe_last_q  <= pipe_last_d;
         for (int s = 0; s < RD_LATENCY; s++) begin
            pipe_src_q[s] <= pipe_src_d[s];
         end
      end
   end

   // Read strobe and consumer outputs, decoded from registered state only
   // (plus the FIFO data mux), so reset forces them low immediately.
   always_comb begin
      fifo_rd_en = '0;
      if (issue) begin
         fifo_rd_en[grant_q] = 1'b1;
      end
      out_valid = pipe_vld_q[TAIL];
      out_data  = '0;
      out_src   = '0;
      out_last  = 1'b0;
      if (out_valid) begin
         out_data = data_arr[pipe_src_q[TAIL]];
         out_src  = pipe_src_q[TAIL];
         out_last = pipe_last_q[TAIL];
      end
      busy = (state_q != ST_IDLE) || (pipe_vld_q != '0);
   end

endmodule

// File: tb/tb_gact_fifo_read_scheduler.sv
// Bench for gact_fifo_read_scheduler. Behavioural FIFOs feed the DUT; when a
// batch of words is loaded into idle FIFOs, a transaction-level model derives
// the full beat order (grant order, burst split, last flags, data) and queues
// it. A monitor on the falling edge pops and compares every presented beat and
// checks the credit, one-hot, latency and forward-progress rules.
module tb_gact_fifo_read_scheduler;

   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int DEP  = 3;
   localparam int CW   = DEP + 1;
   localparam int MAXB = 4;
   localparam int CRED = 4;
   localparam int LAT  = 3;
   localparam int SW   = $clog2(N);

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N*CW-1:0] fifo_count;
   logic [N-1:0]    fifo_rd_en;
   logic [N*DW-1:0] fifo_rd_data;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [SW-1:0]   out_src;
   logic            out_last;
   logic            credit_return;
   logic            busy;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [SW-1:0] src;
      logic          last;
   } beat_t;

   beat_t         exp_q[$];
   int            issue_t[$];
   logic [DW-1:0] fifo_q [N][$];
   logic [DW-1:0] dline  [N][LAT];
   logic [N-1:0]  rd_en_seen = '0;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int credits_m = CRED;
   int idle_run = 0;
   int pending_issue = 0;
   int issued_total = 0;
   int rr_m = 0;
   int credit_pct = 100;
   int credit_pulse = 0;

   gact_fifo_read_scheduler #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH_WIDTH(DEP),
      .MAX_BURST(MAXB), .CREDITS(CRED), .RD_LATENCY(LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .fifo_count(fifo_count), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
      .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_last(out_last),
      .credit_return(credit_return), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit fifos_empty();
      for (int i = 0; i < N; i++) if (fifo_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic load_fifo(input int idx, input int n);
      for (int j = 0; j < n; j++) fifo_q[idx].push_back(DW'($urandom));
   endtask

   // Derive the complete beat sequence for draining the current FIFO
   // contents, assuming no further writes until everything is drained.
   task automatic build_expected();
      int cnt[N];
      int off[N];
      int left = 0;
      int g;
      int blen;
      beat_t b;
      for (int i = 0; i < N; i++) begin
         cnt[i] = fifo_q[i].size();
         off[i] = 0;
         left += cnt[i];
      end
      pending_issue += left;
      while (left > 0) begin
         g = -1;
         for (int k = 0; k < N; k++) begin
`ifdef GACT_SCHED_STRICT_PRIO_EN
            if (g < 0 && cnt[k] > 0) g = k;
`else
            if (g < 0 && cnt[(rr_m + k) % N] > 0) g = (rr_m + k) % N;
`endif
         end
         blen = (cnt[g] < MAXB) ? cnt[g] : MAXB;
         for (int j = 0; j < blen; j++) begin
            b.data = fifo_q[g][off[g] + j];
            b.src  = SW'(g);
            b.last = (j == blen - 1);
            exp_q.push_back(b);
         end
         off[g] += blen;
         cnt[g] -= blen;
         left   -= blen;
`ifndef GACT_SCHED_STRICT_PRIO_EN
         rr_m = (g + 1) % N;
`endif
      end
   endtask

   task automatic wait_drain(input string tag);
      bit done = 1'b0;
      for (int c = 0; c < 4000 && !done; c++) begin
         @(negedge clk);
         #3;
         done = (exp_q.size() == 0) && (pending_issue == 0) && (issue_t.size() == 0)
                && !busy && fifos_empty();
      end
      check({tag, "_drained"}, done, 1);
   endtask

   // FIFO model: apply the reads seen in the previous cycle, age the read
   // data by RD_LATENCY, then present counts, data and the credit return.
   initial begin
      fifo_count    = '0;
      fifo_rd_data  = '0;
      credit_return = 1'b0;
      for (int i = 0; i < N; i++) for (int s = 0; s < LAT; s++) dline[i][s] = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            for (int s = LAT - 1; s > 0; s--) dline[i][s] = dline[i][s-1];
            if (rd_en_seen[i] && fifo_q[i].size() > 0) dline[i][0] = fifo_q[i].pop_front();
            else dline[i][0] = DW'($urandom);
            fifo_count[i*CW +: CW]   = CW'(fifo_q[i].size());
            fifo_rd_data[i*DW +: DW] = dline[i][LAT-1];
         end
         rd_en_seen = '0;
         if (credit_pulse > 0) begin
            credit_return = 1'b1;
            credit_pulse--;
         end else begin
            credit_return = ($urandom_range(99) < credit_pct);
         end
      end
   end

   // Monitor: issue-side rules on fifo_rd_en, scoreboard on out_valid.
   initial begin
      logic [N-1:0] rd;
      int src;
      int c;
      beat_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            credits_m  = CRED;
            idle_run   = 0;
            rd_en_seen = '0;
         end else begin
            rd = fifo_rd_en;
            rd_en_seen = rd;
            if (rd != '0) begin
               src = 0;
               for (int i = N - 1; i >= 0; i--) if (rd[i]) src = i;
               check("rd_en_onehot", $countones(rd), 1);
               check("rd_en_has_credit", credits_m > 0, 1);
               check("rd_en_fifo_nonempty", fifo_q[src].size() > 0, 1);
               issue_t.push_back(cyc);
               issued_total++;
               if (pending_issue > 0) pending_issue--;
               idle_run = 0;
            end else if (pending_issue > 0 && credits_m > 0) begin
               idle_run++;
               check("idle_cycles_with_credit_le2", idle_run <= 2, 1);
            end else begin
               idle_run = 0;
            end
            c = credits_m - ((rd != '0) ? 1 : 0) + (credit_return ? 1 : 0);
            credits_m = (c > CRED) ? CRED : c;
            if (out_valid) begin
               check("busy_with_beat", busy, 1);
               if (exp_q.size() == 0) begin
                  check("unexpected_out_valid", out_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("out_data", out_data, e.data);
                  check("out_src", out_src, e.src);
                  check("out_last", out_last, e.last);
               end
               if (issue_t.size() > 0) check("rd_latency", cyc - issue_t.pop_front(), LAT);
            end
         end
      end
   end

   initial begin
      int base;
      bit found;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_src", out_src, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      #1 rst = 1'b0;

      // One FIFO holding 6 words: bursts of 4 and 2.
      @(negedge clk); #3;
      load_fifo(0, 6);
      build_expected();
      wait_drain("single_fifo6");

      // One word in every FIFO: one grant each, in rotating order.
      @(negedge clk); #3;
      for (int i = 0; i < N; i++) load_fifo(i, 1);
      build_expected();
      wait_drain("all_one");

      // No credit returns: exactly CRED reads, then one per returned credit.
      credit_pct = 0;
      @(negedge clk); #3;
      base = issued_total;
      load_fifo(1, 8);
      build_expected();
      repeat (20) @(negedge clk);
      #3;
      check("stall_issued", issued_total - base, CRED);
      check("stall_idle_busy", busy, 0);
      credit_pulse = 1;
      repeat (12) @(negedge clk);
      #3;
      check("pulse_issued", issued_total - base, CRED + 1);
      check("stall_in_burst_busy", busy, 1);
      credit_pct = 100;
      wait_drain("credit_stall");

      // Random loads with varying credit-return rates.
      for (int r = 0; r < 25; r++) begin
         case (r % 4)
            0: credit_pct = 100;
            1: credit_pct = 60;
            2: credit_pct = 30;
            default: credit_pct = 15;
         endcase
         @(negedge clk); #3;
         for (int i = 0; i < N; i++) load_fifo(i, $urandom_range(2**DEP));
         build_expected();
         wait_drain("random_round");
      end

      // Reset between clock edges in the middle of a burst.
      credit_pct = 60;
      @(negedge clk); #3;
      base = issued_total;
      for (int i = 0; i < N; i++) load_fifo(i, 5);
      build_expected();
      found = 1'b0;
      for (int c = 0; c < 400 && !found; c++) begin
         @(negedge clk);
         #1;
         found = (fifo_rd_en != '0) && (issued_total - base >= 6);
      end
      check("rst_mid_burst_reached", found, 1);
      #1;
      rst = 1'b1;
      rd_en_seen = '0;
      #1;
      check("midrst_rd_en", fifo_rd_en, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data", out_data, 0);
      check("midrst_out_last", out_last, 0);
      check("midrst_busy", busy, 0);
      exp_q.delete();
      issue_t.delete();
      pending_issue = 0;
      repeat (2) @(negedge clk);
      #2;
      rst  = 1'b0;
      rr_m = 0;
      build_expected();
      @(negedge clk);
      #1;
      check("post_rst_no_stale_valid", out_valid, 0);
      wait_drain("after_reset");

      credit_pct = 100;
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
